mult_step_counter: RTL

Parametrised, programmable-length step counter that sequences the iterative multiplier datapath. It counts enabled clock cycles from a start pulse to a run-time terminal value and reports progress with a busy level, a one-cycle done pulse and a sticky flag. It supports up or down counting and one-shot or auto-repeat passes, and a synchronous abort overrides everything else. It sits between the multiplier control FSM and the shift/add stages, replacing the fixed-length enable/flag counter.

---
 rtl/mult_step_counter.sv | 109 ++++++++++
 1 files changed

// File: rtl/mult_step_counter.sv
// Programmable-length step counter that sequences the iterative multiplier datapath.
// Counts enabled RUN cycles from a start pulse to a latched terminal value, up or down, one-shot or repeating.
module mult_step_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             enable_i,
    input  logic             dir_i,
    input  logic             repeat_i,
    input  logic [WIDTH-1:0] tc_value_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             flag_o,
    output logic             dbg_state_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] tc_q, tc_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic             flag_q, flag_d;

    logic [WIDTH-1:0] end_val;
    logic [WIDTH-1:0] reload_val;

    // The end compare fires before any wrap, so the full WIDTH range is usable.
    assign end_val    = dir_q ? '0 : tc_q;
    assign reload_val = dir_q ? tc_q : '0;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = tc_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        flag_d  = flag_q;

        if (abort_i) begin
            state_d = IDLE;
            count_d = '0;
            flag_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        tc_d    = tc_value_i;
                        dir_d   = dir_i;
                        count_d = dir_i ? tc_value_i : '0;
                        flag_d  = 1'b0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (enable_i) begin
                        if (count_q == end_val) begin
                            done_d = 1'b1;
                            flag_d = 1'b1;
                            if (repeat_i) begin
                                count_d = reload_val;
                            end else begin
                                state_d = IDLE;
                            end
                        end else if (dir_q) begin
                            count_d = count_q - 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            tc_q    <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            flag_q  <= flag_d;
        end
    end

    assign count_o     = count_q;
    assign busy_o      = (state_q == RUN);
    assign done_o      = done_q;
    assign flag_o      = flag_q;
    assign dbg_state_o = state_q;

endmodule
